// File: rtl/ex_reg.sv
// ============================================================================
//  Module      : ex_reg
//  Description : EX/MEM pipeline register with signed-overflow exception
//                detection, EX->EX forwarding and a retired-from-EX counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_reg #(
   parameter int         DATA_W     = 32,
   parameter int         ADDR_W     = 5,
   parameter int         MEM_OP_W   = 2,
   parameter int         EXP_W      = 3,
   parameter logic [3:0] ALU_OP_ADD = 4'h0,
   parameter logic [3:0] ALU_OP_SUB = 4'h1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                flush,
   input  logic                id_en,
   input  logic [DATA_W-1:0]   id_pc,
   input  logic [3:0]          id_alu_op,
   input  logic [DATA_W-1:0]   id_arg0,
   input  logic [DATA_W-1:0]   id_arg1,
   input  logic [DATA_W-1:0]   alu_val,
   input  logic [MEM_OP_W-1:0] id_mem_op,
   input  logic [DATA_W-1:0]   id_mem_wr_data,
   input  logic [ADDR_W-1:0]   id_dst_addr,
   input  logic                id_gpr_we,
   input  logic [EXP_W-1:0]    id_exp_code,
   output logic [DATA_W-1:0]   fwd_data,
   output logic                ex_en,
   output logic [DATA_W-1:0]   ex_pc,
   output logic [DATA_W-1:0]   ex_out,
   output logic [MEM_OP_W-1:0] ex_mem_op,
   output logic [DATA_W-1:0]   ex_mem_wr_data,
   output logic [ADDR_W-1:0]   ex_dst_addr,
   output logic                ex_gpr_we,
   output logic [EXP_W-1:0]    ex_exp_code,
   output logic [31:0]         ex_inst_cnt
);

   localparam logic [EXP_W-1:0] C_EXP_NONE = '0;
   localparam logic [EXP_W-1:0] C_EXP_OVF  = EXP_W'(1);

   logic                ex_en_q,          ex_en_d;
   logic [DATA_W-1:0]   ex_pc_q,          ex_pc_d;
   logic [DATA_W-1:0]   ex_out_q,         ex_out_d;
   logic [MEM_OP_W-1:0] ex_mem_op_q,      ex_mem_op_d;
   logic [DATA_W-1:0]   ex_mem_wr_data_q, ex_mem_wr_data_d;
   logic [ADDR_W-1:0]   ex_dst_addr_q,    ex_dst_addr_d;
   logic                ex_gpr_we_q,      ex_gpr_we_d;
   logic [EXP_W-1:0]    ex_exp_code_q,    ex_exp_code_d;
   logic [31:0]         ex_inst_cnt_q,    ex_inst_cnt_d;

   logic w_s0, w_s1, w_sv;
   logic w_ovf;
   logic w_raise_ovf;

   assign w_s0 = id_arg0[DATA_W-1];
   assign w_s1 = id_arg1[DATA_W-1];
   assign w_sv = alu_val[DATA_W-1];

   assign w_ovf = ((id_alu_op == ALU_OP_ADD) && (w_s0 == w_s1) && (w_sv != w_s0)) ||
                  ((id_alu_op == ALU_OP_SUB) && (w_s0 != w_s1) && (w_sv != w_s0));

   // An upstream exception masks overflow; only a clean instruction can raise it.
   assign w_raise_ovf = (id_exp_code == C_EXP_NONE) && w_ovf;

   always_comb begin
      ex_en_d          = ex_en_q;
      ex_pc_d          = ex_pc_q;
      ex_out_d         = ex_out_q;
      ex_mem_op_d      = ex_mem_op_q;
      ex_mem_wr_data_d = ex_mem_wr_data_q;
      ex_dst_addr_d    = ex_dst_addr_q;
      ex_gpr_we_d      = ex_gpr_we_q;
      ex_exp_code_d    = ex_exp_code_q;
      ex_inst_cnt_d    = ex_inst_cnt_q;

      if (!stall) begin
         if (flush || !id_en) begin
            // Bubble: every payload field cleared, counter untouched.
            ex_en_d          = 1'b0;
            ex_pc_d          = '0;
            ex_out_d         = '0;
            ex_mem_op_d      = '0;
            ex_mem_wr_data_d = '0;
            ex_dst_addr_d    = '0;
            ex_gpr_we_d      = 1'b0;
            ex_exp_code_d    = '0;
         end else begin
            ex_en_d          = 1'b1;
            ex_pc_d          = id_pc;
            ex_out_d         = alu_val;
            ex_mem_wr_data_d = id_mem_wr_data;
            ex_dst_addr_d    = id_dst_addr;
            ex_mem_op_d      = w_raise_ovf ? '0   : id_mem_op;
            ex_gpr_we_d      = w_raise_ovf ? 1'b0 : id_gpr_we;
            ex_exp_code_d    = w_raise_ovf ? C_EXP_OVF : id_exp_code;
            ex_inst_cnt_d    = ex_inst_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_en_q          <= 1'b0;
         ex_pc_q          <= '0;
         ex_out_q         <= '0;
         ex_mem_op_q      <= '0;
         ex_mem_wr_data_q <= '0;
         ex_dst_addr_q    <= '0;
         ex_gpr_we_q      <= 1'b0;
         ex_exp_code_q    <= '0;
         ex_inst_cnt_q    <= '0;
      end else begin
         ex_en_q          <= ex_en_d;
         ex_pc_q          <= ex_pc_d;
         ex_out_q         <= ex_out_d;
         ex_mem_op_q      <= ex_mem_op_d;
         ex_mem_wr_data_q <= ex_mem_wr_data_d;
         ex_dst_addr_q    <= ex_dst_addr_d;
         ex_gpr_we_q      <= ex_gpr_we_d;
         ex_exp_code_q    <= ex_exp_code_d;
         ex_inst_cnt_q    <= ex_inst_cnt_d;
      end
   end

   assign fwd_data       = alu_val;
   assign ex_en          = ex_en_q;
   assign ex_pc          = ex_pc_q;
   assign ex_out         = ex_out_q;
   assign ex_mem_op      = ex_mem_op_q;
   assign ex_mem_wr_data = ex_mem_wr_data_q;
   assign ex_dst_addr    = ex_dst_addr_q;
   assign ex_gpr_we      = ex_gpr_we_q;
   assign ex_exp_code    = ex_exp_code_q;
   assign ex_inst_cnt    = ex_inst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_reg.sv
// ============================================================================
//  Module      : tb_ex_reg
//  Description : Directed scoreboard bench for the ex_reg pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_reg;

   typedef struct packed {
      logic        rst, stl, fls, en;
      logic [31:0] pc;
      logic [3:0]  op;
      logic [31:0] a0, a1, val;
      logic [1:0]  mop;
      logic [31:0] wd;
      logic [4:0]  dst;
      logic        we;
      logic [2:0]  exc;
   } stim_t;

   typedef struct packed {
      logic        en;
      logic [31:0] pc, out;
      logic [1:0]  mop;
      logic [31:0] wd;
      logic [4:0]  dst;
      logic        we;
      logic [2:0]  exc;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush, id_en, id_gpr_we;
   logic [31:0] id_pc, id_arg0, id_arg1, alu_val, id_mem_wr_data;
   logic [3:0]  id_alu_op;
   logic [1:0]  id_mem_op;
   logic [4:0]  id_dst_addr;
   logic [2:0]  id_exp_code;
   logic [31:0] fwd_data, ex_pc, ex_out, ex_mem_wr_data, ex_inst_cnt;
   logic        ex_en, ex_gpr_we;
   logic [1:0]  ex_mem_op;
   logic [4:0]  ex_dst_addr;
   logic [2:0]  ex_exp_code;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ex_reg dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_en(id_en),
      .id_pc(id_pc), .id_alu_op(id_alu_op), .id_arg0(id_arg0), .id_arg1(id_arg1),
      .alu_val(alu_val), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .id_dst_addr(id_dst_addr), .id_gpr_we(id_gpr_we), .id_exp_code(id_exp_code),
      .fwd_data(fwd_data), .ex_en(ex_en), .ex_pc(ex_pc), .ex_out(ex_out),
      .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
      .ex_dst_addr(ex_dst_addr), .ex_gpr_we(ex_gpr_we), .ex_exp_code(ex_exp_code),
      .ex_inst_cnt(ex_inst_cnt)
   );

   function automatic stim_t S(input logic rst, stl, fls, en, input logic [31:0] pc,
                               input logic [3:0] op, input logic [31:0] a0, a1, val,
                               input logic [1:0] mop, input logic [31:0] wd,
                               input logic [4:0] dst, input logic we, input logic [2:0] exc);
      return '{rst, stl, fls, en, pc, op, a0, a1, val, mop, wd, dst, we, exc};
   endfunction

   function automatic exp_t E(input logic en, input logic [31:0] pc, out,
                              input logic [1:0] mop, input logic [31:0] wd,
                              input logic [4:0] dst, input logic we, input logic [2:0] exc,
                              input logic [31:0] cnt);
      return '{en, pc, out, mop, wd, dst, we, exc, cnt};
   endfunction

   // Monitor: the register presents a new bundle after every rising edge.
   always @(posedge clk) begin
      exp_t e, g;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         g = '{ex_en, ex_pc, ex_out, ex_mem_op, ex_mem_wr_data, ex_dst_addr,
               ex_gpr_we, ex_exp_code, ex_inst_cnt};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL ex_bundle t=%0t got en=%0b pc=%h out=%h mop=%0d wd=%h dst=%0d we=%0b exc=%0d cnt=%h | want en=%0b pc=%h out=%h mop=%0d wd=%h dst=%0d we=%0b exc=%0d cnt=%h",
                     $time, g.en, g.pc, g.out, g.mop, g.wd, g.dst, g.we, g.exc, g.cnt,
                     e.en, e.pc, e.out, e.mop, e.wd, e.dst, e.we, e.exc, e.cnt);
         end
      end
   end

   task automatic apply(input stim_t s);
      reset = s.rst; stall = s.stl; flush = s.fls; id_en = s.en;
      id_pc = s.pc; id_alu_op = s.op; id_arg0 = s.a0; id_arg1 = s.a1;
      alu_val = s.val; id_mem_op = s.mop; id_mem_wr_data = s.wd;
      id_dst_addr = s.dst; id_gpr_we = s.we; id_exp_code = s.exc;
   endtask

   task automatic step(input stim_t s, input exp_t e);
      @(negedge clk);
      apply(s);
      sb_q.push_back(e);
      #1;
      n_tests++;
      if (fwd_data !== s.val) begin
         n_fail++;
         $display("FAIL fwd_data t=%0t got %h want %h", $time, fwd_data, s.val);
      end
   endtask

   localparam logic [3:0] ADD = 4'h0;
   localparam logic [3:0] SUB = 4'h1;
   localparam logic [3:0] AND_OP = 4'h2;

   initial begin
      stim_t s;
      exp_t  hold;
      int    guard;

      apply(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset for two cycles with random inputs.
      for (int i = 0; i < 2; i++) begin
         s = S(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom, 4'($urandom),
               $urandom, $urandom, $urandom, 2'($urandom), $urandom, 5'($urandom), 1, 3'($urandom));
         step(s, E(0, 0, 0, 0, 0, 0, 0, 0, 0));
      end

      // ADD 5+7.
      step(S(0, 0, 0, 1, 32'h100, ADD, 5, 7, 12, 0, 32'h55, 3, 1, 0),
           E(1, 32'h100, 12, 0, 32'h55, 3, 1, 0, 1));
      // Positive overflow on ADD squashes the store and the write.
      step(S(0, 0, 0, 1, 32'h104, ADD, 32'h7FFFFFFF, 1, 32'h80000000, 2, 32'hAA, 4, 1, 0),
           E(1, 32'h104, 32'h80000000, 0, 32'hAA, 4, 0, 1, 2));
      // SUB overflow with upstream code 4: upstream code wins, write kept.
      step(S(0, 0, 0, 1, 32'h108, SUB, 32'h80000000, 1, 32'h7FFFFFFF, 1, 32'hBB, 5, 1, 4),
           E(1, 32'h108, 32'h7FFFFFFF, 1, 32'hBB, 5, 1, 4, 3));
      // Same SUB overflow with no upstream code.
      step(S(0, 0, 0, 1, 32'h10C, SUB, 32'h80000000, 1, 32'h7FFFFFFF, 1, 32'hCC, 6, 1, 0),
           E(1, 32'h10C, 32'h7FFFFFFF, 0, 32'hCC, 6, 0, 1, 4));
      // -1 + -1: same signs, result stays negative, no overflow.
      step(S(0, 0, 0, 1, 32'h110, ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 32'hDD, 7, 1, 0),
           E(1, 32'h110, 32'hFFFFFFFE, 2, 32'hDD, 7, 1, 0, 5));
      // Non-arithmetic op with overflow-looking operands.
      step(S(0, 0, 0, 1, 32'h114, AND_OP, 32'h7FFFFFFF, 1, 32'h80000000, 1, 32'hEE, 8, 1, 0),
           E(1, 32'h114, 32'h80000000, 1, 32'hEE, 8, 1, 0, 6));
      // id_en=0 is a bubble whatever else is driven.
      step(S(0, 0, 0, 0, 32'h118, ADD, 1, 2, 3, 2, 32'hFF, 9, 1, 5),
           E(0, 0, 0, 0, 0, 0, 0, 0, 6));

      // Latch a valid op, then stall+flush for three cycles.
      hold = E(1, 32'h200, 32'h1234, 1, 32'h77, 10, 1, 0, 7);
      step(S(0, 0, 0, 1, 32'h200, ADD, 32'h1000, 32'h234, 32'h1234, 1, 32'h77, 10, 1, 0), hold);
      for (int i = 0; i < 3; i++)
         step(S(0, 1, 1, 1, 32'h300 + i, ADD, i, i, 32'h50 + i, 2, 32'h99, 11, 1, 2), hold);
      // Flush only.
      step(S(0, 0, 1, 1, 32'h400, ADD, 1, 1, 2, 2, 32'h99, 12, 1, 0),
           E(0, 0, 0, 0, 0, 0, 0, 0, 7));

      // Counter wrap: preload all-ones, then one valid load.
      @(negedge clk);
      force dut.ex_inst_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.ex_inst_cnt_q;
      step(S(0, 0, 0, 1, 32'h500, ADD, 2, 3, 5, 0, 32'h11, 13, 1, 0),
           E(1, 32'h500, 5, 0, 32'h11, 13, 1, 0, 0));
      step(S(0, 0, 0, 1, 32'h504, ADD, 3, 3, 6, 0, 32'h12, 14, 1, 0),
           E(1, 32'h504, 6, 0, 32'h12, 14, 1, 0, 1));
      // Reset beats stall.
      step(S(1, 1, 0, 1, 32'h600, ADD, 1, 1, 2, 1, 32'h13, 15, 1, 0),
           E(0, 0, 0, 0, 0, 0, 0, 0, 0));

      guard = 0;
      while (sb_q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain got %0d pending want 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
